// File: rtl/mips_32.sv
// Five-stage in-order MIPS-subset core with a unified word-addressed memory and an
// internal register file; EX-stage branch resolution with forwarding from EX/MEM and MEM/WB.
module mips_32 #(
    parameter int MEM_DEPTH = 1024
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    logic [31:0] regfile [0:31];
    logic [31:0] mem [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;
    logic        halt_seen;

    logic        if_id_valid;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;

    logic        id_ex_valid;
    logic [5:0]  id_ex_op;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_dest;
    logic        id_ex_we;
    logic [31:0] id_ex_a;
    logic [31:0] id_ex_b;
    logic [31:0] id_ex_imm;
    logic [31:0] id_ex_npc;

    logic        ex_mem_we;
    logic        ex_mem_load;
    logic        ex_mem_store;
    logic        ex_mem_halt;
    logic [4:0]  ex_mem_dest;
    logic [31:0] ex_mem_alu;
    logic [31:0] ex_mem_b;

    logic        mem_wb_we;
    logic        mem_wb_halt;
    logic [4:0]  mem_wb_dest;
    logic [31:0] mem_wb_res;

    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic        id_rr;
    logic        id_ri;
    logic        id_hlt;
    logic        id_we;
    logic [4:0]  id_dest;

    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_opb;
    logic [31:0] ex_alu;
    logic [31:0] ex_target;
    logic        ex_taken;

    logic [31:0] if_ir;
    logic [31:0] mem_rdata;
    logic        stop_fetch;

    assign if_ir     = mem[PC[AW-1:0]];
    assign mem_rdata = mem[ex_mem_alu[AW-1:0]];

    assign id_op   = if_id_ir[31:26];
    assign id_rs   = if_id_ir[25:21];
    assign id_rt   = if_id_ir[20:16];
    assign id_rd   = if_id_ir[15:11];
    assign id_imm  = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
    assign id_rr   = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
    assign id_ri   = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
    assign id_hlt  = if_id_valid && (id_op == OP_HLT);
    assign id_we   = if_id_valid && (id_rr || id_ri || (id_op == OP_LW));
    assign id_dest = id_rr ? id_rd : id_rt;

    // Register read with write-through of the instruction retiring this cycle.
    always_comb begin
        id_a = 32'd0;
        id_b = 32'd0;
        if (id_rs != 5'd0)
            id_a = (mem_wb_we && mem_wb_dest == id_rs) ? mem_wb_res : regfile[id_rs];
        if (id_rt != 5'd0)
            id_b = (mem_wb_we && mem_wb_dest == id_rt) ? mem_wb_res : regfile[id_rt];
    end

    // EX/MEM takes priority over MEM/WB; a load still in EX/MEM has no data yet.
    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
        if (mem_wb_we && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rs) ex_a = mem_wb_res;
        if (mem_wb_we && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rt) ex_b = mem_wb_res;
        if (ex_mem_we && !ex_mem_load && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rs)
            ex_a = ex_mem_alu;
        if (ex_mem_we && !ex_mem_load && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rt)
            ex_b = ex_mem_alu;
    end

    always_comb begin
        ex_opb = (id_ex_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL}) ? ex_b : id_ex_imm;
        ex_alu = 32'd0;
        case (id_ex_op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + ex_opb;
            OP_SUB, OP_SUBI:               ex_alu = ex_a - ex_opb;
            OP_AND:                        ex_alu = ex_a & ex_opb;
            OP_OR:                         ex_alu = ex_a | ex_opb;
            OP_SLT, OP_SLTI:               ex_alu = {31'd0, $signed(ex_a) < $signed(ex_opb)};
            OP_MUL:                        ex_alu = ex_a * ex_opb;
            default:                       ex_alu = 32'd0;
        endcase
    end

    assign ex_target  = id_ex_npc + id_ex_imm;
    assign ex_taken   = id_ex_valid &&
                        (((id_ex_op == OP_BNEQZ) && (ex_a != 32'd0)) ||
                         ((id_ex_op == OP_BEQZ)  && (ex_a == 32'd0)));
    // A taken branch flushes an HLT sitting in ID, so fetch must continue then.
    assign stop_fetch = halt_seen || (id_hlt && !ex_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            PC           <= 32'd0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            halt_seen    <= 1'b0;
            if_id_valid  <= 1'b0;
            if_id_ir     <= 32'd0;
            if_id_npc    <= 32'd0;
            id_ex_valid  <= 1'b0;
            id_ex_op     <= 6'd0;
            id_ex_rs     <= 5'd0;
            id_ex_rt     <= 5'd0;
            id_ex_dest   <= 5'd0;
            id_ex_we     <= 1'b0;
            id_ex_a      <= 32'd0;
            id_ex_b      <= 32'd0;
            id_ex_imm    <= 32'd0;
            id_ex_npc    <= 32'd0;
            ex_mem_we    <= 1'b0;
            ex_mem_load  <= 1'b0;
            ex_mem_store <= 1'b0;
            ex_mem_halt  <= 1'b0;
            ex_mem_dest  <= 5'd0;
            ex_mem_alu   <= 32'd0;
            ex_mem_b     <= 32'd0;
            mem_wb_we    <= 1'b0;
            mem_wb_halt  <= 1'b0;
            mem_wb_dest  <= 5'd0;
            mem_wb_res   <= 32'd0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= ex_taken;
            halt_seen    <= stop_fetch;

            if (ex_taken)
                PC <= ex_target;
            else if (!stop_fetch)
                PC <= PC + 32'd1;

            if (ex_taken || stop_fetch) begin
                if_id_valid <= 1'b0;
                if_id_ir    <= 32'd0;
            end else begin
                if_id_valid <= 1'b1;
                if_id_ir    <= if_ir;
            end
            if_id_npc <= PC + 32'd1;

            id_ex_valid <= if_id_valid && !ex_taken;
            id_ex_we    <= id_we && !ex_taken;
            id_ex_op    <= id_op;
            id_ex_rs    <= id_rs;
            id_ex_rt    <= id_rt;
            id_ex_dest  <= id_dest;
            id_ex_a     <= id_a;
            id_ex_b     <= id_b;
            id_ex_imm   <= id_imm;
            id_ex_npc   <= if_id_npc;

            ex_mem_we    <= id_ex_we;
            ex_mem_load  <= id_ex_valid && (id_ex_op == OP_LW);
            ex_mem_store <= id_ex_valid && (id_ex_op == OP_SW);
            ex_mem_halt  <= id_ex_valid && (id_ex_op == OP_HLT);
            ex_mem_dest  <= id_ex_dest;
            ex_mem_alu   <= ex_alu;
            ex_mem_b     <= ex_b;

            mem_wb_we   <= ex_mem_we;
            mem_wb_halt <= ex_mem_halt;
            mem_wb_dest <= ex_mem_dest;
            mem_wb_res  <= ex_mem_load ? mem_rdata : ex_mem_alu;

            HALTED <= mem_wb_halt;
        end
    end

    // Architectural arrays are never reset so preloaded programs and data survive rst.
    always_ff @(posedge clk) begin
        if (!rst && !HALTED) begin
            if (ex_mem_store)
                mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
            if (mem_wb_we && mem_wb_dest != 5'd0)
                regfile[mem_wb_dest] <= mem_wb_res;
        end
    end
endmodule

// File: tb/tb_mips_32.sv
// Directed program bench for mips_32: programs are preloaded under reset, expected
// architectural results are queued and then compared once the core halts.
module tb_mips_32;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_32 dut (
        .clk(clk),
        .rst(rst)
    );

    int checks = 0;
    int errors = 0;
    int taken_cnt = 0;
    logic [31:0] exp_q[$];
    int          loc_q[$];
    string       tag_q[$];

    localparam logic [31:0] HLT = 32'hfc000000;

    always @(negedge clk)
        if (!rst && dut.TAKEN_BRANCH === 1'b1) taken_cnt++;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "global timeout");
    end

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_reg(input string tag, input int idx, input logic [31:0] val);
        exp_q.push_back(val);
        loc_q.push_back(idx);
        tag_q.push_back(tag);
    endtask

    task automatic expect_mem(input string tag, input int addr, input logic [31:0] val);
        exp_q.push_back(val);
        loc_q.push_back(32 + addr);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        logic [31:0] e;
        logic [31:0] obs;
        int          l;
        string       t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = loc_q.pop_front();
            t = tag_q.pop_front();
            obs = (l < 32) ? dut.regfile[l] : dut.mem[l - 32];
            check(t, obs, e);
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.mem[i] = 32'd0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (dut.HALTED !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, dut.HALTED}, 32'd1);
        @(negedge clk);
    endtask

    task automatic load_loop();
        dut.mem[200] = 32'd7;
        dut.mem[0] = enc_i(6'b001010, 5'd0, 5'd10, 16'd200);
        dut.mem[1] = enc_i(6'b001010, 5'd0, 5'd2, 16'd1);
        dut.mem[2] = enc_i(6'b001000, 5'd10, 5'd3, 16'd0);
        dut.mem[3] = enc_r(6'b000011, 5'd7, 5'd7, 5'd7);
        dut.mem[4] = enc_r(6'b000101, 5'd2, 5'd3, 5'd2);
        dut.mem[5] = enc_i(6'b001011, 5'd3, 5'd3, 16'd1);
        dut.mem[6] = enc_i(6'b001101, 5'd3, 5'd0, 16'hfffd);
        dut.mem[7] = enc_i(6'b001001, 5'd10, 5'd2, 16'hfffe);
        dut.mem[8] = HLT;
    endtask

    initial begin
        logic [31:0] pc_at_halt;

        for (int i = 0; i < 32; i++) dut.regfile[i] = 32'd0;
        hold_reset();
        @(negedge clk);
        check("rst_pc", dut.PC, 32'd0);
        check("rst_halted", {31'd0, dut.HALTED}, 32'd0);
        check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        // Basic program with spacers
        dut.mem[0] = 32'h2801000a;
        dut.mem[1] = 32'h28020014;
        dut.mem[2] = 32'h28030019;
        dut.mem[3] = 32'h0ce73800;
        dut.mem[4] = 32'h0ce00000;
        dut.mem[5] = 32'h00222000;
        dut.mem[6] = 32'h0ce73800;
        dut.mem[7] = 32'h00832800;
        dut.mem[8] = HLT;
        expect_reg("p1_r0", 0, 32'd0);
        expect_reg("p1_r1", 1, 32'd10);
        expect_reg("p1_r2", 2, 32'd20);
        expect_reg("p1_r3", 3, 32'd25);
        expect_reg("p1_r4", 4, 32'd30);
        expect_reg("p1_r5", 5, 32'd55);
        rst = 1'b0;
        run_to_halt("p1_halt_in_20", 20);
        drain();

        // Back-to-back forwarding
        hold_reset();
        dut.mem[0] = enc_i(6'b001010, 5'd0, 5'd1, 16'd5);
        dut.mem[1] = enc_r(6'b000000, 5'd1, 5'd1, 5'd2);
        dut.mem[2] = enc_r(6'b000001, 5'd2, 5'd1, 5'd3);
        dut.mem[3] = HLT;
        expect_reg("fw_r1", 1, 32'd5);
        expect_reg("fw_r2", 2, 32'd10);
        expect_reg("fw_r3", 3, 32'd5);
        rst = 1'b0;
        run_to_halt("fw_halt", 40);
        drain();

        // Load, spacer, dependent add, store
        hold_reset();
        dut.mem[120] = 32'd85;
        dut.mem[0] = enc_i(6'b001010, 5'd0, 5'd1, 16'd120);
        dut.mem[1] = enc_i(6'b001000, 5'd1, 5'd2, 16'd0);
        dut.mem[2] = enc_r(6'b000011, 5'd7, 5'd7, 5'd7);
        dut.mem[3] = enc_i(6'b001010, 5'd2, 5'd2, 16'd45);
        dut.mem[4] = enc_i(6'b001001, 5'd1, 5'd2, 16'd1);
        dut.mem[5] = HLT;
        expect_mem("ls_mem121", 121, 32'd130);
        expect_reg("ls_r2", 2, 32'd130);
        rst = 1'b0;
        run_to_halt("ls_halt", 40);
        drain();

        // Factorial loop with taken branches
        hold_reset();
        load_loop();
        expect_mem("loop_mem198", 198, 32'd5040);
        expect_reg("loop_r2", 2, 32'd5040);
        expect_reg("loop_r3", 3, 32'd0);
        expect_mem("loop_mem7", 7, enc_i(6'b001001, 5'd10, 5'd2, 16'hfffe));
        taken_cnt = 0;
        rst = 1'b0;
        run_to_halt("loop_halt", 200);
        drain();
        check("loop_taken_pulses", taken_cnt, 32'd6);

        // HLT stops younger instructions; R0 is never written
        hold_reset();
        dut.regfile[9] = 32'h12345678;
        dut.mem[0] = enc_i(6'b001010, 5'd0, 5'd0, 16'd5);
        dut.mem[1] = HLT;
        dut.mem[2] = enc_i(6'b001001, 5'd0, 5'd0, 16'd0);
        dut.mem[3] = enc_i(6'b001010, 5'd0, 5'd9, 16'd1);
        expect_reg("hlt_r0", 0, 32'd0);
        expect_reg("hlt_r9", 9, 32'h12345678);
        expect_mem("hlt_mem0", 0, 32'h28000005);
        rst = 1'b0;
        run_to_halt("hlt_halt", 40);
        drain();
        pc_at_halt = dut.PC;
        check("hlt_pc", pc_at_halt, 32'd2);
        repeat (5) @(negedge clk);
        check("hlt_pc_frozen", dut.PC, pc_at_halt);
        check("hlt_still_halted", {31'd0, dut.HALTED}, 32'd1);

        // Reset mid-loop, on the edge where a taken branch resolves
        hold_reset();
        load_loop();
        rst = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        dut.mem[198] = 32'd0;
        @(negedge clk);
        check("mid_rst_pc", dut.PC, 32'd0);
        check("mid_rst_halted", {31'd0, dut.HALTED}, 32'd0);
        check("mid_rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        taken_cnt = 0;
        rst = 1'b0;
        @(negedge clk);
        check("mid_restart_pc", dut.PC, 32'd1);
        expect_mem("mid_mem198", 198, 32'd5040);
        run_to_halt("mid_halt", 200);
        drain();
        check("mid_taken_pulses", taken_cnt, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
